// File: rtl/postmortem_capture_ctrl_pkg.sv
// Shared types and default sizing for the postmortem capture sequencer.
package postmortem_capture_ctrl_pkg;

  localparam int unsigned DefDepth  = 50000;
  localparam int unsigned DefAddrW  = 16;
  localparam int unsigned DefDecimW = 16;

  // Encoding is visible to software through the state output.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFill   = 3'd1,
    StArmed  = 3'd2,
    StPost   = 3'd3,
    StFrozen = 3'd4
  } state_e;

endpackage

// File: rtl/postmortem_capture_ctrl_if.sv
// Control/status bundle between the capture sequencer and its host.
// Optional macro POSTMORTEM_TIMESTAMP_EN adds the trig_ts field.
interface postmortem_capture_ctrl_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DECIM_W = 16
);
  logic               arm;
  logic               intl_flag;
  logic [DECIM_W-1:0] decim;
  logic [ADDR_W-1:0]  post_cnt;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  trig_addr;
  logic [ADDR_W-1:0]  last_addr;
  logic [2:0]         state;
  logic               partial;
  logic               irq;
`ifdef POSTMORTEM_TIMESTAMP_EN
  logic [31:0]        trig_ts;

  modport master (
    output arm, intl_flag, decim, post_cnt,
    input  wr_en, wr_addr, trig_addr, last_addr, state, partial, irq, trig_ts
  );
  modport slave (
    input  arm, intl_flag, decim, post_cnt,
    output wr_en, wr_addr, trig_addr, last_addr, state, partial, irq, trig_ts
  );
`else
  modport master (
    output arm, intl_flag, decim, post_cnt,
    input  wr_en, wr_addr, trig_addr, last_addr, state, partial, irq
  );
  modport slave (
    input  arm, intl_flag, decim, post_cnt,
    output wr_en, wr_addr, trig_addr, last_addr, state, partial, irq
  );
`endif
endinterface

// File: rtl/postmortem_sample_tick.sv
// Sample prescaler: counts 0..last and emits a 1-cycle tick on 'last'.
module postmortem_sample_tick #(
  parameter int unsigned DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DECIM_W-1:0] last,
  output logic               tick
);

  logic [DECIM_W-1:0] cnt_q, cnt_d;

  // Next count and tick; clear wins over enable and suppresses the tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= last) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/postmortem_capture_ctrl.sv
// Postmortem capture sequencer: sample strobe, circular write pointer,
// trigger detection and post-trigger window.
// Optional macro POSTMORTEM_TIMESTAMP_EN adds a trigger timestamp.
module postmortem_capture_ctrl
  import postmortem_capture_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DECIM_W = DefDecimW
) (
  input logic                      clk,
  input logic                      rst_n,
  postmortem_capture_ctrl_if.slave bus
);

  localparam int unsigned      CntW     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [CntW-1:0]   DepthC   = CntW'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, prev_q, prev_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d, last_q, last_d;
  logic [ADDR_W-1:0]   post_q, post_d, post_seen_q, post_seen_d;
  logic [CntW-1:0]     fill_q, fill_d;
  logic [DECIM_W-1:0]  dlast_q, dlast_d;
  logic                partial_q, partial_d, flag_q, irq_q;
  logic                active, wr, trig;
  logic [ADDR_W-1:0]   ptr_inc;
  logic [CntW-1:0]     fill_target;

  assign active = (state_q == StFill) || (state_q == StArmed) || (state_q == StPost);
  // Arm outranks a coincident edge.
  assign trig = bus.intl_flag && !flag_q && !bus.arm &&
                ((state_q == StFill) || (state_q == StArmed));
  assign ptr_inc     = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
  assign fill_target = DepthC - {1'b0, post_q};

  postmortem_sample_tick #(
    .DECIM_W(DECIM_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.arm),
    .en   (active),
    .last (dlast_q),
    .tick (wr)
  );

  // Next-state: pointer, counters, FSM transitions and captured addresses.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prev_d      = prev_q;
    fill_d      = fill_q;
    post_seen_d = post_seen_q;
    trig_addr_d = trig_addr_q;
    last_d      = last_q;
    partial_d   = partial_q;
    dlast_d     = dlast_q;
    post_d      = post_q;

    if (wr) begin
      wr_ptr_d = ptr_inc;
      prev_d   = wr_ptr_q;
    end

    unique case (state_q)
      StFill: begin
        if (wr) fill_d = fill_q + 1'b1;
        if (wr && !trig && (fill_q + 1'b1 == fill_target)) state_d = StArmed;
      end
      StPost: begin
        if (wr) begin
          post_seen_d = post_seen_q + 1'b1;
          if (post_seen_q + 1'b1 == post_q) begin
            state_d = StFrozen;
            last_d  = wr_ptr_q;
          end
        end
      end
      default: ;
    endcase

    if (trig) begin
      // A tick in the trigger cycle is still a pre-trigger sample.
      trig_addr_d = wr ? ptr_inc : wr_ptr_q;
      post_seen_d = '0;
      if (state_q == StFill) partial_d = 1'b1;
      if (post_q == '0) begin
        state_d = StFrozen;
        last_d  = wr ? wr_ptr_q : prev_q;
      end else begin
        state_d = StPost;
      end
    end

    if (bus.arm) begin
      state_d     = StFill;
      wr_ptr_d    = '0;
      prev_d      = '0;
      fill_d      = '0;
      post_seen_d = '0;
      trig_addr_d = '0;
      partial_d   = 1'b0;
      dlast_d     = (bus.decim == '0) ? '0 : bus.decim - 1'b1;
      post_d      = (bus.post_cnt > LastAddr) ? LastAddr : bus.post_cnt;
    end
  end

  // State registers; the edge register resets high so a flag already high does not trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      prev_q      <= '0;
      fill_q      <= '0;
      post_seen_q <= '0;
      trig_addr_q <= '0;
      last_q      <= '0;
      partial_q   <= 1'b0;
      dlast_q     <= '0;
      post_q      <= '0;
      flag_q      <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prev_q      <= prev_d;
      fill_q      <= fill_d;
      post_seen_q <= post_seen_d;
      trig_addr_q <= trig_addr_d;
      last_q      <= last_d;
      partial_q   <= partial_d;
      dlast_q     <= dlast_d;
      post_q      <= post_d;
      flag_q      <= bus.intl_flag;
      irq_q       <= (state_d == StFrozen) && (state_q != StFrozen);
    end
  end

  assign bus.wr_en     = wr;
  assign bus.wr_addr   = wr_ptr_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.last_addr = last_q;
  assign bus.state     = state_q;
  assign bus.partial   = partial_q;
  assign bus.irq       = irq_q;

`ifdef POSTMORTEM_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, trig_ts_q, trig_ts_d;

  // Sample counter and its snapshot at the trigger, including that cycle's tick.
  always_comb begin
    ts_d      = bus.arm ? '0 : ts_q + 32'(wr);
    trig_ts_d = trig ? ts_q + 32'(wr) : trig_ts_q;
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_q      <= ts_d;
      trig_ts_q <= trig_ts_d;
    end
  end

  assign bus.trig_ts = trig_ts_q;
`endif

endmodule
